clk_div_n: RTL and testbench
============================

Name: clk_div_n

Overview:
- Programmable clock divider directly downstream of the divide-value selector.
- Consumes the 32-bit divide value (`div_n`, system clock cycles per output period) and produces a divided clock-enable waveform `out_clk` (~50% duty), a one-cycle `tick` at each period end, and a wrapping period counter.
- A new `div_n` takes effect only at a period boundary, so a `sel` change never produces a runt or stretched half-period.

Parameters:
- WIDTH, 32: width of `div_n` and the internal counter.
- MIN_DIV, 2: smallest accepted divide value; smaller inputs are clamped to this.
- PCNT_W, 16: width of the `period_cnt` output.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  run enable; low holds the divider idle.
- div_n  input  WIDTH  requested period in clk cycles, driven by the selector; may change at any time.
- out_clk  output  1  divided waveform (registered level, not used as a clock).
- tick  output  1  one-cycle pulse in the last cycle of each period.
- reloaded  output  1  one-cycle pulse in the first cycle of a period that uses a new `div_n` value.
- period_cnt  output  PCNT_W  count of completed periods; wraps.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, cnt=0, act_n=MIN_DIV.
  - out_clk=0, tick=0, reloaded=0, period_cnt=0.
  - Reset overrides all other inputs, including mid-period.
- Clamp: eff_n = (div_n < MIN_DIV) ? MIN_DIV : div_n. The comparison is unsigned.
- High phase: H = act_n − floor(act_n/2), i.e. ceil(act_n/2).
- State IDLE:
  - cnt=0, out_clk=0, tick=0.
  - If en=1 is sampled: next cycle state=RUN, act_n=eff_n, cnt=0, out_clk=1.
  - The reload from IDLE does not pulse `reloaded`.
- State RUN, every cycle:
  - out_clk=1 exactly in cycles where cnt<H; out_clk=0 where H≤cnt≤act_n−1.
  - tick=1 exactly in the cycle where cnt==act_n−1.
  - Outputs are registered and consistent with the displayed cnt; the implementation computes them from the next-state value.
- Period end (cnt==act_n−1 and en=1), next cycle:
  - cnt=0.
  - period_cnt += 1, wrapping 2^PCNT_W−1 → 0.
  - act_n = eff_n as sampled in that end cycle.
  - reloaded=1 if the new act_n ≠ old act_n, else 0.
- Mid-period `div_n` changes are ignored until the period end; only the value present in the end cycle is used.
- en=0 sampled in RUN:
  - Next cycle state=IDLE; cnt, out_clk and tick clear to 0.
  - The partial period is not counted.
  - period_cnt holds its value; it is not cleared.
- en=0 coincident with a period end: the period is counted (period_cnt increments) and state goes to IDLE.
- Width rules:
  - cnt is WIDTH bits and never exceeds act_n−1, so no overflow is possible.
  - act_n = 2^WIDTH−1 is legal.
- Latency:
  - First out_clk high 1 cycle after en is sampled high.
  - First tick act_n cycles after that.

Test Plan:
- Reset then en=1, div_n=4 → out_clk 1,1,0,0 repeating; tick on every 4th RUN cycle; period_cnt=1,2,3 after successive ticks.
- div_n=5 → out_clk 1,1,1,0,0 (H=3); tick on cycle 5.
- div_n=0 and div_n=1 → both behave as 2: out_clk toggles 1,0; tick every other cycle.
- div_n=4 running, switch to 6 at cnt=1 → current period completes as 4 cycles; next period is 6 cycles (1,1,1,0,0,0); reloaded pulses once at that period's cnt=0. Switch 6→8→6 within one period → no reload, no reloaded pulse.
- en=0 at cnt=2 of an N=4 period → next cycle out_clk=0, tick=0, period_cnt unchanged. en=0 at cnt=3 → period_cnt increments and state goes to IDLE. Re-enable → out_clk=1 one cycle later, cnt restarts at 0.
- Preload period_cnt near wrap (PCNT_W=4, run 16 periods) → period_cnt goes 15→0. rst_n=0 mid-period → every output is 0 on the next cycle.

Source files
------------

// File: rtl/clk_div_n_if.sv
// Signal bundle between the divide-value selector and the clock divider.
// The selector side (master) drives en/div_n; the divider (slave) returns its outputs.
interface clk_div_n_if #(
    parameter int WIDTH  = 32,
    parameter int PCNT_W = 16
);
    logic              en;
    logic [WIDTH-1:0]  div_n;
    logic              out_clk;
    logic              tick;
    logic              reloaded;
    logic [PCNT_W-1:0] period_cnt;

    modport master (
        output en, div_n,
        input  out_clk, tick, reloaded, period_cnt
    );

    modport slave (
        input  en, div_n,
        output out_clk, tick, reloaded, period_cnt
    );
endinterface

// File: rtl/clk_div_n.sv
// Programmable clock-enable divider: ~50% duty out_clk, end-of-period tick, period counter.
// A new divide value is only adopted at a period boundary, so half-periods are never runt.
module clk_div_n #(
    parameter int WIDTH   = 32,
    parameter int MIN_DIV = 2,
    parameter int PCNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    clk_div_n_if.slave  bus
);
    localparam logic [0:0]       S_IDLE = 1'b0;
    localparam logic [0:0]       S_RUN  = 1'b1;
    localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    logic [0:0]        state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  act_q, act_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              out_clk_q, out_clk_d;
    logic              tick_q, tick_d;
    logic              rel_q, rel_d;
    logic [WIDTH-1:0]  eff_n;
    logic              last;
    logic              run_d;

    function automatic logic [WIDTH-1:0] clamp_n(input logic [WIDTH-1:0] n);
        return (n < MIN_N) ? MIN_N : n;
    endfunction

    // Length of the high phase, ceil(n/2), computed without overflow at n = 2^WIDTH-1.
    function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] n);
        return n - (n >> 1);
    endfunction

    assign eff_n = clamp_n(bus.div_n);
    assign last  = (cnt_q == act_q - ONE_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pcnt_d  = pcnt_q;
        rel_d   = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (bus.en) begin
                state_d = S_RUN;
                act_d   = eff_n;
            end
        end else begin
            // A completed period is counted even when en drops in its last cycle.
            if (last) begin
                pcnt_d = pcnt_q + PCNT_W'(1);
            end
            if (!bus.en) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (last) begin
                cnt_d = '0;
                act_d = eff_n;
                rel_d = (eff_n != act_q);
            end else begin
                cnt_d = cnt_q + ONE_W;
            end
        end

        // Outputs are derived from the next state so they line up with the registered cnt.
        run_d     = (state_d == S_RUN);
        out_clk_d = run_d && (cnt_d < high_len(act_d));
        tick_d    = run_d && (cnt_d == act_d - ONE_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            act_q     <= MIN_N;
            pcnt_q    <= '0;
            out_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            pcnt_q    <= pcnt_d;
            out_clk_q <= out_clk_d;
            tick_q    <= tick_d;
            rel_q     <= rel_d;
        end
    end

    assign bus.out_clk    = out_clk_q;
    assign bus.tick       = tick_q;
    assign bus.reloaded   = rel_q;
    assign bus.period_cnt = pcnt_q;
endmodule

// File: tb/tb_clk_div_n.sv
// Bench for clk_div_n: directed scenarios then random stimulus, checked every cycle
// against a period-level reference model (position in period, active divide, count).
module tb_clk_div_n;
    localparam int WIDTH  = 32;
    localparam int PCNT_W = 4;

    logic clk;
    logic rst_n;

    clk_div_n_if #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) bus ();

    clk_div_n #(
        .WIDTH  (WIDTH),
        .MIN_DIV(2),
        .PCNT_W (PCNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state
    bit      m_run;
    longint  m_pos;
    longint  m_act;
    int      m_pcnt;
    bit      m_rel;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint eff_of(input logic [WIDTH-1:0] d);
        longint v;
        v = longint'(d);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_edge(input bit r, input bit e, input logic [WIDTH-1:0] d);
        bit at_end;
        m_rel = 1'b0;
        if (!r) begin
            m_run = 0; m_pos = 0; m_act = 2; m_pcnt = 0;
        end else if (!m_run) begin
            if (e) begin
                m_run = 1; m_pos = 0; m_act = eff_of(d);
            end
        end else begin
            at_end = (m_pos == m_act - 1);
            if (at_end) m_pcnt = (m_pcnt + 1) % (1 << PCNT_W);
            if (!e) begin
                m_run = 0; m_pos = 0;
            end else if (at_end) begin
                m_rel = (eff_of(d) != m_act);
                m_act = eff_of(d);
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then compare.
    task automatic step(input bit r, input bit e, input logic [WIDTH-1:0] d);
        longint high;
        rst_n     = r;
        bus.en    = e;
        bus.div_n = d;
        @(posedge clk);
        model_edge(r, e, d);
        #1;
        high = (m_act + 1) / 2;
        check("out_clk",    bus.out_clk,    (m_run && m_pos < high) ? 1 : 0);
        check("tick",       bus.tick,       (m_run && m_pos == m_act - 1) ? 1 : 0);
        check("reloaded",   bus.reloaded,   m_rel);
        check("period_cnt", bus.period_cnt, m_pcnt);
    endtask

    task automatic run_n(input int n, input bit e, input logic [WIDTH-1:0] d);
        for (int i = 0; i < n; i++) step(1'b1, e, d);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_run = 0; m_pos = 0; m_act = 2; m_pcnt = 0; m_rel = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.div_n = '0;

        step(1'b0, 1'b1, 32'd4);
        step(1'b0, 1'b0, 32'd4);

        // Basic divides, including clamped values
        run_n(20, 1'b1, 32'd4);
        run_n(15, 1'b1, 32'd5);
        run_n(10, 1'b1, 32'd0);
        run_n(10, 1'b1, 32'd1);

        // Switch mid-period 4 -> 6, then wiggle 6 -> 8 -> 6 inside one period
        run_n(8, 1'b1, 32'd4);
        run_n(1, 1'b1, 32'd4);
        run_n(12, 1'b1, 32'd6);
        step(1'b1, 1'b1, 32'd8);
        step(1'b1, 1'b1, 32'd8);
        run_n(10, 1'b1, 32'd6);

        // en drops mid-period and at period end, then re-enable
        step(1'b0, 1'b0, 32'd4);
        run_n(3, 1'b1, 32'd4);
        step(1'b1, 1'b0, 32'd4);
        run_n(3, 1'b0, 32'd4);
        run_n(4, 1'b1, 32'd4);
        step(1'b1, 1'b0, 32'd4);
        run_n(6, 1'b1, 32'd4);

        // Maximum divide value, started from idle
        step(1'b1, 1'b0, 32'hFFFF_FFFF);
        run_n(10, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 32'd2);

        // period_cnt wrap, then reset mid-period
        run_n(40, 1'b1, 32'd2);
        run_n(3, 1'b1, 32'd7);
        step(1'b0, 1'b1, 32'd7);
        run_n(2, 1'b1, 32'd3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] d;
            bit e, r;
            d = (($urandom_range(0, 49)) == 0) ? $urandom() : 32'($urandom_range(0, 9));
            e = ($urandom_range(0, 19) != 0);
            r = ($urandom_range(0, 199) != 0);
            step(r, e, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
